// File: rtl/pw_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : pw_pkg
//  Purpose   : Shared constants and types for the password-check front end.
//  Revision  : 1.0  initial release
// ============================================================================
package pw_pkg;

   // Width of the code switch bank, also used by the password checker.
   localparam int SW_W          = 8;

   // Short debounce window used for simulation builds.
   localparam int DB_CYCLES_SIM = 4;
   localparam int CNT_W_SIM     = 3;

   // Button events. The encoding doubles as the priority rank:
   // a larger code wins arbitration (Res > Lock > Confirm).
   typedef enum logic [1:0] {
      EV_NONE    = 2'd0,
      EV_CONFIRM = 2'd1,
      EV_LOCK    = 2'd2,
      EV_RES     = 2'd3
   } pw_event_e;

   // Pick the single highest-priority button event of this cycle.
   // Losers are simply not returned, i.e. they are dropped.
   function automatic pw_event_e pw_arbitrate(input logic i_res,
                                              input logic i_lock,
                                              input logic i_cfm);
      pw_event_e w_ev;
      w_ev = EV_NONE;
      if (i_res) begin
         w_ev = EV_RES;
      end else if (i_lock) begin
         w_ev = EV_LOCK;
      end else if (i_cfm) begin
         w_ev = EV_CONFIRM;
      end
      return w_ev;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pw_debounce_cell.sv
`default_nettype none
// ============================================================================
//  Module    : pw_debounce_cell
//  Purpose   : Two-flop synchroniser plus counter-based debouncer for a
//              W-bit channel. A new vector is accepted only after it has been
//              seen unchanged for DB_CYCLES consecutive cycles.
//  Revision  : 1.0  initial release
// ============================================================================
module pw_debounce_cell #(
   parameter int W         = 1,
   parameter int DB_CYCLES = 4,
   parameter int CNT_W     = 3
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic [W-1:0] i_raw,
   output logic [W-1:0] o_stable
);
   import pw_pkg::*;

   localparam logic [CNT_W-1:0] c_limit = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

   // Reject parameter sets where the counter could not reach the limit.
   if ((DB_CYCLES < 2) || ((2 ** CNT_W) <= DB_CYCLES)) begin : g_param_check
      $error("pw_debounce_cell: need DB_CYCLES >= 2 and 2**CNT_W > DB_CYCLES");
   end

   logic [W-1:0]     r_s1;
   logic [W-1:0]     r_s2;
   logic [W-1:0]     r_cand;
   logic [W-1:0]     r_stable;
   logic [CNT_W-1:0] r_cnt;

   // Two-stage synchroniser for the asynchronous raw input.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1 <= '0;
         r_s2 <= '0;
      end else begin
         r_s1 <= i_raw;
         r_s2 <= r_s1;
      end
   end

   // Debounce: count consecutive cycles the same new vector is seen.
   // r_cand holds the vector being timed; any differing bit restarts the
   // run with the current cycle counted as its first, so the whole vector
   // is accepted atomically and never a mix of old and new bits.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cand   <= '0;
         r_stable <= '0;
         r_cnt    <= '0;
      end else if (r_s2 == r_stable) begin
         r_cand <= r_s2;
         r_cnt  <= '0;
      end else if (r_s2 != r_cand) begin
         r_cand <= r_s2;
         r_cnt  <= c_one;
      end else if (r_cnt == c_limit) begin
         r_stable <= r_s2;
         r_cnt    <= '0;
      end else begin
         r_cnt <= r_cnt + c_one;
      end
   end

   assign o_stable = r_stable;

endmodule
`default_nettype wire

// File: rtl/pw_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module    : pw_input_conditioner
//  Purpose   : Front end of the password checker. Synchronises and debounces
//              the code switches, enable switch and three push-buttons, turns
//              button presses into arbitrated single-cycle pulses and
//              publishes the switch bank as one atomically updated code.
//  Revision  : 1.0  initial release
// ============================================================================
module pw_input_conditioner #(
   parameter int SW_W      = pw_pkg::SW_W,
   parameter int DB_CYCLES = 1000000,
   parameter int CNT_W     = 20
) (
   input  logic            Clk,
   input  logic            Rst_n,
   input  logic [SW_W-1:0] sw_raw,
   input  logic            en_raw,
   input  logic            btn_cfm,
   input  logic            btn_lock,
   input  logic            btn_res,
   output logic [SW_W-1:0] in_8,
   output logic            En,
   output logic            sw_chg,
   output logic            Confirm,
   output logic            Lock,
   output logic            Res
);
   import pw_pkg::*;

   // Single-bit channels packed as {res, lock, cfm, en}.
   localparam int c_n_bits = 4;
   localparam int c_en     = 0;
   localparam int c_cfm    = 1;
   localparam int c_lock   = 2;
   localparam int c_res    = 3;

   logic [c_n_bits-1:0] w_bit_raw;
   logic [c_n_bits-1:0] w_bit_stable;
   logic [SW_W-1:0]     w_sw_stable;

   logic                r_cfm_q;
   logic                r_lock_q;
   logic                r_res_q;
   logic                w_cfm_rise;
   logic                w_lock_rise;
   logic                w_res_rise;
   pw_event_e           w_grant;

   logic [SW_W-1:0]     r_in_8;
   logic                r_en;
   logic                r_sw_chg;
   logic                r_confirm;
   logic                r_lock;
   logic                r_res;

   assign w_bit_raw = {btn_res, btn_lock, btn_cfm, en_raw};

   // The whole switch bank is one channel so it changes as a unit.
   pw_debounce_cell #(
      .W         (SW_W),
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
   ) u_sw_cell (
      .i_clk    (Clk),
      .i_rst_n  (Rst_n),
      .i_raw    (sw_raw),
      .o_stable (w_sw_stable)
   );

   for (genvar g = 0; g < c_n_bits; g++) begin : g_bit_cell
      pw_debounce_cell #(
         .W         (1),
         .DB_CYCLES (DB_CYCLES),
         .CNT_W     (CNT_W)
      ) u_cell (
         .i_clk    (Clk),
         .i_rst_n  (Rst_n),
         .i_raw    (w_bit_raw[g]),
         .o_stable (w_bit_stable[g])
      );
   end

   // Rising-edge detection on the debounced buttons and priority arbitration.
   always_comb begin
      w_cfm_rise  = w_bit_stable[c_cfm]  & ~r_cfm_q;
      w_lock_rise = w_bit_stable[c_lock] & ~r_lock_q;
      w_res_rise  = w_bit_stable[c_res]  & ~r_res_q;
      w_grant     = pw_arbitrate(w_res_rise, w_lock_rise, w_cfm_rise);
   end

   // Output registers; sw_chg compares against the code currently published.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_cfm_q   <= 1'b0;
         r_lock_q  <= 1'b0;
         r_res_q   <= 1'b0;
         r_in_8    <= '0;
         r_en      <= 1'b0;
         r_sw_chg  <= 1'b0;
         r_confirm <= 1'b0;
         r_lock    <= 1'b0;
         r_res     <= 1'b0;
      end else begin
         r_cfm_q   <= w_bit_stable[c_cfm];
         r_lock_q  <= w_bit_stable[c_lock];
         r_res_q   <= w_bit_stable[c_res];
         r_in_8    <= w_sw_stable;
         r_en      <= w_bit_stable[c_en];
         r_sw_chg  <= (w_sw_stable != r_in_8);
         r_confirm <= (w_grant == EV_CONFIRM);
         r_lock    <= (w_grant == EV_LOCK);
         r_res     <= (w_grant == EV_RES);
      end
   end

   assign in_8    = r_in_8;
   assign En      = r_en;
   assign sw_chg  = r_sw_chg;
   assign Confirm = r_confirm;
   assign Lock    = r_lock;
   assign Res     = r_res;

endmodule
`default_nettype wire
